// File: rtl/bram_arb_pkg.sv
// Shared definitions for the two-master block-RAM arbiter.
// Holds the FSM state encoding, master count, bus widths and the read strobe value.
package bram_arb_pkg;

  localparam int unsigned NUM_MASTERS = 2;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned STRB_W      = 4;

  // All-zero strobe marks a read; also the idle value of the RAM write enables.
  localparam logic [STRB_W-1:0] WSTRB_READ = 4'b0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/bram_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the shared RAM.
//   m_valid/m_addr*/m_wdata*/m_wstrb*  : master requests (byte addresses, 0 strobe = read)
//   m_ready/m_rdata                    : one-cycle completion pulse and read data
//   ram_valid/ram_addr/ram_wen/ram_wdata : single-cycle RAM access
//   ram_ready/ram_rdata                : RAM acknowledge and read data
// Modports: slave = arbiter view, master = environment (masters + RAM) view.
interface bram_arbiter_if
  import bram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);

  logic [NUM_MASTERS-1:0] m_valid;
  logic [DATA_W-1:0]      m_addr0;
  logic [DATA_W-1:0]      m_addr1;
  logic [DATA_W-1:0]      m_wdata0;
  logic [DATA_W-1:0]      m_wdata1;
  logic [STRB_W-1:0]      m_wstrb0;
  logic [STRB_W-1:0]      m_wstrb1;
  logic [NUM_MASTERS-1:0] m_ready;
  logic [DATA_W-1:0]      m_rdata;

  logic                   ram_valid;
  logic [ADDR_W-1:0]      ram_addr;
  logic [STRB_W-1:0]      ram_wen;
  logic [DATA_W-1:0]      ram_wdata;
  logic                   ram_ready;
  logic [DATA_W-1:0]      ram_rdata;

  modport slave (
    input  m_valid, m_addr0, m_addr1, m_wdata0, m_wdata1, m_wstrb0, m_wstrb1,
    output m_ready, m_rdata,
    output ram_valid, ram_addr, ram_wen, ram_wdata,
    input  ram_ready, ram_rdata
  );

  modport master (
    output m_valid, m_addr0, m_addr1, m_wdata0, m_wdata1, m_wstrb0, m_wstrb1,
    input  m_ready, m_rdata,
    input  ram_valid, ram_addr, ram_wen, ram_wdata,
    output ram_ready, ram_rdata
  );

endinterface

// File: rtl/bram_arb_pick.sv
// Combinational grant selection between the two masters.
// Macro BRAM_ARB_ROUND_ROBIN_EN: ties go to the master not granted last (last_grant input).
// Otherwise: fixed priority, master 0 wins ties, no last_grant input.
// Ports: valid (request vector), [last_grant], grant_c (winner index), any_c (some request).
module bram_arb_pick
  import bram_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] valid,
`ifdef BRAM_ARB_ROUND_ROBIN_EN
  input  logic                   last_grant,
`endif
  output logic                   grant_c,
  output logic                   any_c
);

  assign any_c = |valid;

`ifdef BRAM_ARB_ROUND_ROBIN_EN
  // Tie: alternate away from the previous winner; single request: that master.
  assign grant_c = (valid == 2'b11) ? ~last_grant : valid[1];
`else
  // Master 1 only wins when master 0 is not requesting.
  assign grant_c = valid[1] & ~valid[0];
`endif

endmodule

// File: rtl/bram_arbiter.sv
// Two-master arbiter for a single-port block RAM with 1-cycle registered ready.
// Each transaction runs IDLE -> ACCESS -> WAIT -> RESP: the RAM is strobed for exactly
// one cycle in ACCESS and the winner gets a one-cycle registered m_ready pulse in RESP.
// Ports: clk, reset (async, active high), bus (bram_arbiter_if.slave).
// Optional macro BRAM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned WORDS  = 256,
  parameter int unsigned ADDR_W = $clog2(WORDS)
)(
  input  logic            clk,
  input  logic            reset,
  bram_arbiter_if.slave   bus
);

  state_t                 state;
  logic                   grant_q;
  logic [NUM_MASTERS-1:0] m_ready_q;
  logic [DATA_W-1:0]      m_rdata_q;
  logic                   ram_valid_q;
  logic [ADDR_W-1:0]      ram_addr_q;
  logic [STRB_W-1:0]      ram_wen_q;
  logic [DATA_W-1:0]      ram_wdata_q;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
  logic                   last_grant_q;
`endif

  logic                   pick_grant_c;
  logic                   pick_any_c;
  logic [DATA_W-1:0]      sel_addr_c;
  logic [DATA_W-1:0]      sel_wdata_c;
  logic [STRB_W-1:0]      sel_wstrb_c;

  // Grant selection
  bram_arb_pick u_pick (
    .valid      (bus.m_valid),
`ifdef BRAM_ARB_ROUND_ROBIN_EN
    .last_grant (last_grant_q),
`endif
    .grant_c    (pick_grant_c),
    .any_c      (pick_any_c)
  );

  // Request payload of the candidate winner
  assign sel_addr_c  = pick_grant_c ? bus.m_addr1  : bus.m_addr0;
  assign sel_wdata_c = pick_grant_c ? bus.m_wdata1 : bus.m_wdata0;
  assign sel_wstrb_c = pick_grant_c ? bus.m_wstrb1 : bus.m_wstrb0;

  // Transaction FSM; the RAM-side registers double as the request latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      grant_q      <= 1'b0;
      m_ready_q    <= '0;
      m_rdata_q    <= '0;
      ram_valid_q  <= 1'b0;
      ram_addr_q   <= '0;
      ram_wen_q    <= WSTRB_READ;
      ram_wdata_q  <= '0;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_any_c) begin
            grant_q     <= pick_grant_c;
            // Word address: drop byte offset, wrap modulo depth by truncation.
            ram_addr_q  <= ADDR_W'(sel_addr_c >> 2);
            ram_wdata_q <= sel_wdata_c;
            ram_wen_q   <= sel_wstrb_c;
            ram_valid_q <= 1'b1;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
            last_grant_q <= pick_grant_c;
`endif
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          ram_valid_q <= 1'b0;
          ram_wen_q   <= WSTRB_READ;
          state       <= WAIT;
        end
        WAIT: begin
          if (bus.ram_ready) begin
            m_rdata_q <= bus.ram_rdata;
            m_ready_q <= NUM_MASTERS'(1) << grant_q;
            state     <= RESP;
          end
        end
        RESP: begin
          m_ready_q <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_ready   = m_ready_q;
  assign bus.m_rdata   = m_rdata_q;
  assign bus.ram_valid = ram_valid_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wen   = ram_wen_q;
  assign bus.ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: behavioural RAM, shadow memory reference model,
// rule-based grant prediction, and per-scenario tasks with inline comparisons.
module tb_bram_arbiter;
  import bram_arb_pkg::*;

  localparam int unsigned WORDS  = 256;
  localparam int unsigned ADDR_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bram_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  bram_arbiter #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int model_last = 1;
  bit ram_init = 1'b0;

  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];

  int rv_cnt = 0;
  int rv_cyc = 0;
  int rv_cyc_prev = 0;
  bit rv_prev = 1'b0;
  bit wen_viol = 1'b0;
  bit dbl_viol = 1'b0;
  logic [ADDR_W-1:0] last_ram_addr;
  logic [3:0]        last_ram_wen;
  logic [31:0]       last_ram_wdata;

  function automatic logic [31:0] init_word(input int unsigned i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: registered read of old contents, ready one cycle after valid.
  always @(posedge clk) begin
    bus.ram_ready <= 1'b0;
    if (ram_init) begin
      for (int i = 0; i < int'(WORDS); i++) mem[i] <= init_word(i);
    end else if (bus.ram_valid === 1'b1) begin
      bus.ram_rdata <= mem[bus.ram_addr];
      for (int b = 0; b < 4; b++)
        if (bus.ram_wen[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      bus.ram_ready <= 1'b1;
    end
  end

  // RAM strobe observer
  always @(negedge clk) begin
    if (bus.ram_valid === 1'b1) begin
      if (rv_prev) dbl_viol = 1'b1;
      rv_cnt++;
      rv_cyc_prev = rv_cyc;
      rv_cyc = cyc;
      last_ram_addr = bus.ram_addr;
      last_ram_wen = bus.ram_wen;
      last_ram_wdata = bus.ram_wdata;
    end else if (bus.ram_wen !== 4'b0000) begin
      wen_viol = 1'b1;
    end
    rv_prev = (bus.ram_valid === 1'b1);
  end

  // Expected winner from the arbitration rule
  function automatic int pick_model(input logic [1:0] p);
    if (p == 2'b11) begin
`ifdef BRAM_ARB_ROUND_ROBIN_EN
      return (model_last == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return p[1] ? 1 : 0;
  endfunction

  // Issue requests (caller at a negedge, arbiter idle) and check every completion.
  task automatic serve(input logic [1:0] req,
                       input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                       input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1);
    logic [31:0] addr [2];
    logic [31:0] wd [2];
    logic [3:0]  st [2];
    logic [1:0]  pend;
    logic [1:0]  exp_rdy;
    int win, t0, n, rv0, lat;
    int unsigned w;
    addr[0] = a0; wd[0] = d0; st[0] = s0;
    addr[1] = a1; wd[1] = d1; st[1] = s1;
    bus.m_addr0 = a0; bus.m_wdata0 = d0; bus.m_wstrb0 = s0;
    bus.m_addr1 = a1; bus.m_wdata1 = d1; bus.m_wstrb1 = s1;
    bus.m_valid = req;
    pend = req;
    t0 = cyc;
    lat = 3;
    while (pend != 2'b00) begin
      win = pick_model(pend);
      w = (addr[win] >> 2) % WORDS;
      rv0 = rv_cnt;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.m_ready === 2'b00 && n < 20);
      total++;
      if (bus.m_ready === 2'b00) begin
        $display("FAIL serve_timeout: no m_ready after %0d cycles, want master %0d", n, win);
        bus.m_valid = 2'b00;
        return;
      end else passed++;
      exp_rdy = 2'b01 << win;
      total++;
      if (bus.m_ready !== exp_rdy) $display("FAIL grant: m_ready=%b want %b", bus.m_ready, exp_rdy);
      else passed++;
      total++;
      if (cyc - t0 !== lat) $display("FAIL latency: %0d cycles want %0d", cyc - t0, lat);
      else passed++;
      total++;
      if (bus.m_rdata !== ref_mem[w]) $display("FAIL rdata: got %h want %h (word %0d)", bus.m_rdata, ref_mem[w], w);
      else passed++;
      total++;
      if (rv_cnt - rv0 !== 1 || last_ram_addr !== ADDR_W'(w) || last_ram_wen !== st[win])
        $display("FAIL ram_access: strobes=%0d addr=%0d wen=%b want 1 %0d %b",
                 rv_cnt - rv0, last_ram_addr, last_ram_wen, w, st[win]);
      else passed++;
      if (st[win] != 4'b0000) begin
        total++;
        if (last_ram_wdata !== wd[win]) $display("FAIL ram_wdata: got %h want %h", last_ram_wdata, wd[win]);
        else passed++;
      end
      total++;
      if (wen_viol || dbl_viol) $display("FAIL strobe_shape: wen_outside=%0d double_valid=%0d want 0 0", wen_viol, dbl_viol);
      else passed++;
      for (int b = 0; b < 4; b++)
        if (st[win][b]) ref_mem[w][8*b +: 8] = wd[win][8*b +: 8];
      model_last = win;
      bus.m_valid[win] = 1'b0;
      pend[win] = 1'b0;
      t0 = cyc;
      lat = 4;
      @(negedge clk);
      total++;
      if (bus.m_ready !== 2'b00) $display("FAIL pulse_width: m_ready=%b want 00", bus.m_ready);
      else passed++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ram_init = 1'b1;
    bus.m_valid = 2'b00;
    bus.m_addr0 = '0; bus.m_wdata0 = '0; bus.m_wstrb0 = '0;
    bus.m_addr1 = '0; bus.m_wdata1 = '0; bus.m_wstrb1 = '0;
    for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = init_word(i);
    repeat (2) @(negedge clk);
    ram_init = 1'b0;
    total++; if (bus.m_ready !== 2'b00) $display("FAIL rst_m_ready: got %b want 00", bus.m_ready); else passed++;
    total++; if (bus.m_rdata !== 32'h0) $display("FAIL rst_m_rdata: got %h want 0", bus.m_rdata); else passed++;
    total++; if (bus.ram_valid !== 1'b0) $display("FAIL rst_ram_valid: got %b want 0", bus.ram_valid); else passed++;
    total++; if (bus.ram_wen !== 4'h0) $display("FAIL rst_ram_wen: got %b want 0000", bus.ram_wen); else passed++;
    total++; if (bus.ram_addr !== '0) $display("FAIL rst_ram_addr: got %h want 0", bus.ram_addr); else passed++;
    total++; if (bus.ram_wdata !== 32'h0) $display("FAIL rst_ram_wdata: got %h want 0", bus.ram_wdata); else passed++;
    @(negedge clk);
    reset = 1'b0;
    model_last = 1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    serve(2'b01, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 32'h0, 4'h0);
    serve(2'b01, 32'h10, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
    total++; if (bus.m_rdata !== 32'hDEADBEEF) $display("FAIL single_read_data: got %h want deadbeef", bus.m_rdata); else passed++;
    total++; if (last_ram_addr !== 8'd4) $display("FAIL single_read_addr: got %0d want 4", last_ram_addr); else passed++;
  endtask

  task automatic test_byte_write();
    serve(2'b10, 32'h0, 32'h0, 4'h0, 32'h8, 32'h11223344, 4'hF);
    serve(2'b10, 32'h0, 32'h0, 4'h0, 32'h8, 32'h000000AB, 4'b0001);
    total++; if (last_ram_wen !== 4'b0001) $display("FAIL byte_wen: got %b want 0001", last_ram_wen); else passed++;
    serve(2'b10, 32'h0, 32'h0, 4'h0, 32'h8, 32'h0, 4'h0);
    total++; if (bus.m_rdata !== 32'h112233AB) $display("FAIL byte_merge: got %h want 112233ab", bus.m_rdata); else passed++;
  endtask

  task automatic test_wrap();
    serve(2'b01, 32'h400, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
    total++; if (last_ram_addr !== 8'd0) $display("FAIL wrap_addr: got %0d want 0", last_ram_addr); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [3:0]  s [2];
    for (int it = 0; it < 40; it++) begin
      for (int m = 0; m < 2; m++) begin
        a[m] = ($urandom() & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
        d[m] = $urandom();
        s[m] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom());
      end
      serve(2'($urandom_range(1, 3)), a[0], d[0], s[0], a[1], d[1], s[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a0, a1;
    logic [1:0]  pend;
    int win, n, t0, cnt0;
    int unsigned w;
    a0 = $urandom();
    a1 = $urandom();
    bus.m_addr0 = a0; bus.m_wdata0 = $urandom(); bus.m_wstrb0 = 4'h0;
    bus.m_addr1 = a1; bus.m_wdata1 = $urandom(); bus.m_wstrb1 = 4'h0;
    bus.m_valid = 2'b11;
    pend = 2'b11;
    t0 = cyc;
    cnt0 = 0;
    for (int k = 0; k < 4; k++) begin
      win = pick_model(pend);
      w = (((win == 0) ? a0 : a1) >> 2) % WORDS;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.m_ready === 2'b00 && n < 20);
      total++;
      if (bus.m_ready === 2'b00) begin
        $display("FAIL b2b_timeout: no m_ready at completion %0d", k);
        break;
      end else passed++;
      total++;
      if (bus.m_ready !== (2'b01 << win)) $display("FAIL b2b_grant%0d: m_ready=%b want master %0d", k, bus.m_ready, win);
      else passed++;
      total++;
      if (cyc - t0 !== ((k == 0) ? 3 : 4)) $display("FAIL b2b_spacing%0d: %0d cycles want %0d", k, cyc - t0, (k == 0) ? 3 : 4);
      else passed++;
      total++;
      if (bus.m_rdata !== ref_mem[w]) $display("FAIL b2b_rdata%0d: got %h want %h", k, bus.m_rdata, ref_mem[w]);
      else passed++;
      if (k > 0) begin
        total++;
        if (rv_cyc - rv_cyc_prev !== 4) $display("FAIL b2b_ram_gap%0d: %0d cycles want 4", k, rv_cyc - rv_cyc_prev);
        else passed++;
      end
      model_last = win;
`ifndef BRAM_ARB_ROUND_ROBIN_EN
      if (win == 0) begin
        cnt0++;
        if (cnt0 == 3) begin bus.m_valid[0] = 1'b0; pend[0] = 1'b0; end
      end
`endif
      t0 = cyc;
    end
    bus.m_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, d;
    int unsigned w;
    bit seen;
    a = 32'h0000_0040 | (32'($urandom_range(0, 3)) << 2);
    d = $urandom();
    w = (a >> 2) % WORDS;
    bus.m_addr0 = a; bus.m_wdata0 = d; bus.m_wstrb0 = 4'hF;
    bus.m_valid = 2'b01;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++; if (bus.m_ready !== 2'b00) $display("FAIL mid_rst_m_ready: got %b want 00", bus.m_ready); else passed++;
    total++; if (bus.ram_valid !== 1'b0) $display("FAIL mid_rst_ram_valid: got %b want 0", bus.ram_valid); else passed++;
    total++; if (bus.ram_wen !== 4'h0) $display("FAIL mid_rst_ram_wen: got %b want 0000", bus.ram_wen); else passed++;
    total++; if (bus.m_rdata !== 32'h0) $display("FAIL mid_rst_m_rdata: got %h want 0", bus.m_rdata); else passed++;
    total++; if (bus.ram_addr !== '0) $display("FAIL mid_rst_ram_addr: got %h want 0", bus.ram_addr); else passed++;
    bus.m_valid = 2'b00;
    ref_mem[w] = d;
    model_last = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.m_ready !== 2'b00) seen = 1'b1;
    end
    total++; if (seen) $display("FAIL mid_rst_dropped: m_ready seen=1 want 0"); else passed++;
    serve(2'b01, a, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
    total++; if (bus.m_rdata !== d) $display("FAIL mid_rst_write_stands: got %h want %h", bus.m_rdata, d); else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_byte_write();
    test_wrap();
    test_back_to_back();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-requester arbiter that shares one single-port word-wide block RAM (1-cycle registered read, registered `ready` one cycle after `valid`, per-byte write enables) between the CPU native memory bus and a secondary master (loader/DMA). Sits between the SoC interconnect and the RAM instance. It serialises accesses through a small FSM, drives the RAM for exactly one cycle per transaction, and returns a registered one-cycle `ready` pulse plus read data to the winning master.

## Interface
Parameters:
- `WORDS`, 256, RAM depth in 32-bit words.
- `ADDR_W`, log2(`WORDS`), RAM word-address width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `m_valid`  in  2  per-master request; held high until that master's `m_ready` pulse.
- `m_addr0`, `m_addr1`  in  32  byte addresses; bits [ADDR_W+1:2] used.
- `m_wdata0`, `m_wdata1`  in  32  write data.
- `m_wstrb0`, `m_wstrb1`  in  4  byte strobes; 0 = read.
- `m_ready`  out  2  one-cycle completion pulse, one-hot or zero.
- `m_rdata`  out  32  read data, valid while the matching `m_ready` bit is high.
- `ram_valid`  out  1  RAM access strobe.
- `ram_addr`  out  ADDR_W  RAM word address.
- `ram_wen`  out  4  RAM byte write enables.
- `ram_wdata`  out  32  RAM write data.
- `ram_ready`  in  1  RAM acknowledge.
- `ram_rdata`  in  32  RAM read data.

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: if any `m_valid`, choose the grant, latch addr/wdata/wstrb of the winner, go to ACCESS; else stay.
- ACCESS: `ram_valid`=1, `ram_wen`=latched strobe, `ram_addr`/`ram_wdata` from latches; go to WAIT.
- WAIT: `ram_valid`=0, `ram_wen`=0; on `ram_ready`=1 register `ram_rdata` into `m_rdata`, set `m_ready[grant]`=1 and go to RESP; else stay.
- RESP: `m_ready` pulse visible for this cycle only. Clear it and go to IDLE.
- Writes also return `m_ready`. `m_rdata` holds the RAM's output for that address (pre-write contents) and masters ignore it.
- A master's `m_valid` that is still high in the IDLE following its own RESP is treated as a new request.
- Upper address bits above ADDR_W+1 and bits [1:0] are ignored. Out-of-range addresses wrap modulo `WORDS`.
- Request inputs are sampled only in IDLE. Changes during ACCESS/WAIT/RESP have no effect on the current transaction.

## Timing
- Reset values: state=IDLE, `m_ready`=0, `m_rdata`=0, `ram_valid`=0, `ram_wen`=0, `ram_addr`=0, `ram_wdata`=0, last-grant=1.
- Latency: request sampled in IDLE at edge N, then ACCESS in cycle N+1, WAIT in cycle N+2 (RAM acks), and `m_ready` high in cycle N+3. Throughput is one transaction per 4 cycles.
- `ram_valid` and `ram_wen` are high for exactly one cycle per transaction. They are never high outside ACCESS.
- Reset asserted mid-transaction: all outputs go to reset values immediately and asynchronously. The partial transaction is dropped with no `m_ready`. Any write already strobed in ACCESS stands.
- If `ram_ready` never arrives, the FSM stays in WAIT indefinitely; there is no timeout.

## Configuration
- `BRAM_ARB_ROUND_ROBIN_EN` defined: when both masters request in IDLE, grant the master not granted last. Last-grant updates on every grant. After reset, master 0 wins the first tie.
- Not defined: fixed priority, so master 0 always wins ties. The last-grant register is not implemented.

## Structure
- Shared package `bram_arb_pkg` holds:
  - state encoding constants IDLE/ACCESS/WAIT/RESP (2-bit);
  - `NUM_MASTERS`=2;
  - `WSTRB_READ`=4'b0000.
- One sub-module `bram_arb_pick`: combinational grant selection from `m_valid` and last-grant. It contains the macro-dependent logic; the FSM stays in the top.

## Test plan
- Single read: write 0xDEADBEEF to byte addr 0x10 beforehand, then master 0 reads 0x10. Expect `ram_valid` one cycle with `ram_addr`=4, `m_ready`=2'b01 exactly 3 cycles after sampling, and `m_rdata`=0xDEADBEEF.
- Byte write: master 1 writes 0x000000AB to addr 0x8 with strobe 4'b0001 over a word holding 0x11223344. Expect `ram_wen`=4'b0001 for one cycle and `m_ready`=2'b10; a subsequent read returns 0x112233AB.
- Simultaneous requests with macro defined: both masters hold `m_valid` continuously. Grants alternate 0,1,0,1; each `m_ready` pulse is one cycle, and `ram_valid` pulses are 4 cycles apart.
- Simultaneous requests without macro: master 0 holds `m_valid` for 3 transactions while master 1 waits. Expect three master-0 completions, then master 1 is served.
- Wrap: `WORDS`=256, read byte addr 0x400. Expect `ram_addr`=0.
- Reset mid-operation: assert `reset` during WAIT. Expect `m_ready`=0 and `ram_valid`=0 immediately, state IDLE; after release, a new request completes normally.
